// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer that turns a bit-reversed FFT output stream into natural order.
// One bank fills while the other is read out, and the banks swap on each accepted isync.
module fft_bitrev_reorder #(
    parameter int STG = 4,
    parameter int DW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 isync,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 ovld,
    output logic [STG-1:0]       oidx,
    output logic                 osync,
    output logic                 sync_err
);

    localparam int LEN = 1 << STG;
    localparam logic [STG-1:0] LAST = STG'(LEN - 1);

    function automatic logic [STG-1:0] bitrev(input logic [STG-1:0] a);
        logic [STG-1:0] r;
        for (int i = 0; i < STG; i++) begin
            r[i] = a[STG-1-i];
        end
        return r;
    endfunction

    // Bank select is the address MSB: entries [0..LEN-1] are bank 0, [LEN..2*LEN-1] bank 1.
    logic signed [DW-1:0] mem_re [0:2*LEN-1];
    logic signed [DW-1:0] mem_im [0:2*LEN-1];

    logic [STG-1:0] wcnt_p0;
    logic           wbank_p0;
    logic           rd_act_p0;
    logic [STG-1:0] rcnt_p0;

    logic           swap;
    logic           rd_go;
    logic [STG:0]   waddr;
    logic [STG:0]   raddr;

    assign swap  = en & isync;
    assign rd_go = en & rd_act_p0;
    assign waddr = {wbank_p0, bitrev(wcnt_p0)};
    assign raddr = {~wbank_p0, rcnt_p0};

    // Stage p0: write side, bank ownership and read address generation
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            mem_re[waddr] <= in_re;
            mem_im[waddr] <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_p0   <= '0;
            wbank_p0  <= 1'b0;
            rd_act_p0 <= 1'b0;
            rcnt_p0   <= '0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= swap & (wcnt_p0 != LAST);
            if (swap) begin
                // A swap always restarts the read, truncating any frame still draining.
                wcnt_p0   <= '0;
                wbank_p0  <= ~wbank_p0;
                rd_act_p0 <= 1'b1;
                rcnt_p0   <= '0;
            end else if (en) begin
                wcnt_p0 <= wcnt_p0 + STG'(1);
                if (rd_act_p0) begin
                    rcnt_p0 <= rcnt_p0 + STG'(1);
                    if (rcnt_p0 == LAST) begin
                        rd_act_p0 <= 1'b0;
                    end
                end
            end
        end
    end

    // Stage p1: registered read data and its qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            ovld  <= 1'b0;
            osync <= 1'b0;
            oidx  <= '0;
        end else if (en) begin
            ovld  <= rd_act_p0;
            osync <= rd_act_p0 & (rcnt_p0 == LAST);
            if (rd_act_p0) begin
                oidx <= rcnt_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_re <= '0;
            out_im <= '0;
        end else if (rd_go) begin
            out_re <= mem_re[raddr];
            out_im <= mem_im[raddr];
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: directed table, hand-written corner sequences and
// randomized traffic compared against a frame-level queue model.
module tb_fft_bitrev_reorder;

    localparam int STG = 4;
    localparam int DW  = 16;
    localparam int LEN = 1 << STG;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 isync;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 ovld;
    logic [STG-1:0]       oidx;
    logic                 osync;
    logic                 sync_err;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.STG(STG), .DW(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_re(in_re), .in_im(in_im), .isync(isync),
        .out_re(out_re), .out_im(out_im), .ovld(ovld), .oidx(oidx), .osync(osync),
        .sync_err(sync_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int brev(input int x);
        int r = 0;
        int v = x;
        for (int i = 0; i < STG; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // Reference model: banks as plain arrays; a completed frame becomes a queue of
    // natural-order samples awaiting readout.
    typedef struct { int idx; int re; int im; bit known; } ent_t;
    ent_t rq[$];
    int   mb_re [2][LEN];
    int   mb_im [2][LEN];
    bit   mb_kn [2][LEN];
    int   mwb = 0;
    int   mk  = 0;
    bit   e_ovld, e_osync, e_serr, e_known;
    int   e_oidx, e_re, e_im;

    task automatic model_step(input bit r, input bit e, input bit s, input int re, input int im);
        ent_t ent;
        int   a;
        if (r) begin
            mwb = 0; mk = 0; rq.delete();
            e_ovld = 0; e_osync = 0; e_serr = 0; e_oidx = 0; e_re = 0; e_im = 0; e_known = 1;
            return;
        end
        e_serr = e && s && (mk != LEN - 1);
        if (e) begin
            if (rq.size() > 0) begin
                ent = rq.pop_front();
                e_ovld = 1; e_oidx = ent.idx; e_re = ent.re; e_im = ent.im;
                e_known = ent.known; e_osync = (ent.idx == LEN - 1);
            end else begin
                e_ovld = 0; e_osync = 0;
            end
            a = brev(mk);
            mb_re[mwb][a] = re; mb_im[mwb][a] = im; mb_kn[mwb][a] = 1;
            if (s) begin
                rq.delete();
                for (int n = 0; n < LEN; n++) begin
                    ent.idx = n; ent.re = mb_re[mwb][n]; ent.im = mb_im[mwb][n];
                    ent.known = mb_kn[mwb][n];
                    rq.push_back(ent);
                end
                mwb = 1 - mwb;
                mk = 0;
            end else begin
                mk = (mk + 1) % LEN;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit s,
                        input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
        rst = r; en = e; isync = s; in_re = re; in_im = im;
        model_step(r, e, s, int'(re), int'(im));
        @(posedge clk);
        #1;
        check("ovld", int'(ovld), int'(e_ovld));
        check("osync", int'(osync), int'(e_osync));
        check("sync_err", int'(sync_err), int'(e_serr));
        check("oidx", int'(oidx), e_oidx);
        if (e_known) begin
            check("out_re", int'(out_re), e_re);
            check("out_im", int'(out_im), e_im);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0, '0, '0);
    endtask

    typedef struct {
        bit en; bit isync; int re; int im;
        bit x_ovld; int x_oidx; bit x_osync; int x_re; int x_im;
    } vec_t;
    vec_t tbl[34];

    initial begin
        int nv, ns, ne, first_v, last_v, nxt;
        bit pv; int pre;

        for (int c = 0; c < 34; c++) begin
            tbl[c].en = 1;
            tbl[c].isync = (c == 15);
            tbl[c].re = (c < 16) ? brev(c) * 100 : 0;
            tbl[c].im = -tbl[c].re;
            tbl[c].x_ovld = (c >= 16 && c <= 31);
            tbl[c].x_oidx = c - 16;
            tbl[c].x_osync = (c == 31);
            tbl[c].x_re = (c - 16) * 100;
            tbl[c].x_im = -(c - 16) * 100;
        end

        do_reset(2);
        check("rst_ovld", int'(ovld), 0);
        check("rst_oidx", int'(oidx), 0);
        check("rst_out_re", int'(out_re), 0);

        // Single frame in bit-reversed order, read back in natural order.
        for (int c = 0; c < 34; c++) begin
            step(0, tbl[c].en, tbl[c].isync, DW'(tbl[c].re), DW'(tbl[c].im));
            check("tbl_ovld", int'(ovld), int'(tbl[c].x_ovld));
            check("tbl_osync", int'(osync), int'(tbl[c].x_osync));
            if (tbl[c].x_ovld) begin
                check("tbl_oidx", int'(oidx), tbl[c].x_oidx);
                check("tbl_re", int'(out_re), tbl[c].x_re);
                check("tbl_im", int'(out_im), tbl[c].x_im);
            end
        end

        // Three back-to-back frames: continuous ovld, osync every 16th.
        do_reset(1);
        nv = 0; ns = 0; ne = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 48 + 20; c++) begin
            step(0, 1, (c < 48) && (c % LEN == LEN - 1), DW'($urandom), DW'($urandom));
            if (ovld) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (osync) ns++;
            if (sync_err) ne++;
        end
        check("b2b_vld_count", nv, 48);
        check("b2b_vld_span", last_v - first_v + 1, 48);
        check("b2b_osync_count", ns, 3);
        check("b2b_sync_err", ne, 0);

        // Strobe toggling: same output sequence, frozen while en is low.
        do_reset(1);
        nxt = 0; pv = ovld; pre = int'(out_re);
        for (int j = 0; j < 80; j++) begin
            bit e;
            int v;
            e = (j % 2 == 0);
            v = (j < 32) ? brev(j / 2) * 100 : 0;
            step(0, e, (j == 30), DW'(v), DW'(-v));
            if (!e) begin
                check("tog_hold_vld", int'(ovld), int'(pv));
                check("tog_hold_re", int'(out_re), pre);
            end else if (ovld) begin
                check("tog_oidx", int'(oidx), nxt);
                check("tog_re", int'(out_re), nxt * 100);
                nxt++;
            end
            pv = ovld; pre = int'(out_re);
        end
        check("tog_count", nxt, 16);

        // Early isync after 10 samples, then a full frame.
        do_reset(1);
        for (int k = 0; k < 10; k++) step(0, 1, (k == 9), DW'(k + 7), DW'(-k));
        check("mis_err_pulse", int'(sync_err), 1);
        ne = 0; ns = 0;
        for (int k = 0; k < 16 + 20; k++) begin
            step(0, 1, (k == 15), DW'(brev(k % LEN) * 3 - 20), DW'(k));
            if (sync_err) ne++;
            if (osync) ns++;
        end
        check("mis_err_after", ne, 0);
        check("mis_osync", ns, 2);

        // Reset mid-frame discards partial input and in-flight output.
        do_reset(1);
        for (int k = 0; k < 16 + 7; k++) step(0, 1, (k == 15), DW'($urandom), DW'($urandom));
        check("rst_mid_pre_vld", int'(ovld), 1);
        step(1, 1, 0, '0, '0);
        check("rst_mid_vld", int'(ovld), 0);
        step(1, 1, 0, '0, '0);
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            step(0, 1, (k == 15), DW'(brev(k) * 11), DW'(-brev(k)));
            if (ovld) nv++;
        end
        check("rst_mid_quiet", nv, 0);
        step(0, 1, 0, '0, '0);
        check("rst_mid_resume", int'(ovld), 1);
        check("rst_mid_first", int'(out_re), 0);
        step(0, 1, 0, '0, '0);
        check("rst_mid_second", int'(out_re), 11);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            bit r, e, s;
            r = ($urandom % 150 == 0);
            e = ($urandom % 4 != 0);
            s = ((mk == LEN - 1) && ($urandom % 8 != 0)) || ($urandom % 50 == 0);
            step(r, e, s, DW'($urandom), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter STG, default 4, log2 of frame length; LEN = 2**STG.
REQ-002 SHALL have parameter DW, default 16, signed width of each real/imag component.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 en  input  1  sample strobe; input accepted and read pipeline advanced only when high.
REQ-006 in_re  input  DW  signed real part of FFT output sample, bit-reversed order.
REQ-007 in_im  input  DW  signed imaginary part, same timing as in_re.
REQ-008 isync  input  1  high with the last sample of an input frame; qualified by en.
REQ-009 out_re  output  DW  signed real part, natural order.
REQ-010 out_im  output  DW  signed imaginary part, natural order.
REQ-011 ovld  output  1  out_re/out_im/oidx valid this cycle.
REQ-012 oidx  output  STG  natural frequency index of current output sample.
REQ-013 osync  output  1  high with ovld on the last sample (oidx = LEN-1) of an output frame.
REQ-014 sync_err  output  1  one-cycle pulse when isync arrives with write count != LEN-1.

Function
REQ-015 SHALL hold two LEN-entry banks (ping-pong); write bank and read bank always differ.
REQ-016 Write counter wcnt (STG bits): accepted sample k of a frame written to write bank at address bitrev(wcnt); wcnt increments per accepted sample, wraps LEN-1 -> 0.
REQ-017 Accepted isync: wcnt -> 0, write/read banks swap, read of completed bank armed; effective next cycle.
REQ-018 Misaligned isync (wcnt != LEN-1): same swap as REQ-017, sync_err pulses next cycle; unwritten entries keep stale contents, no further correction.
REQ-019 wcnt wrapping without isync SHALL NOT swap banks (frame continues overwriting same bank).
REQ-020 Read counter rcnt (STG bits) issues addresses 0..LEN-1 in natural order, one per en-high cycle while read active.
REQ-021 Read RAM output registered: ovld, oidx, out_re/out_im appear exactly one en-high cycle after address issue; with en continuous, first output (oidx=0) valid 2 cycles after isync cycle.
REQ-022 When en low: rcnt, outputs and ovld hold; ovld deasserts only via REQ-024.
REQ-023 Read of LEN-1 coinciding with a new swap: next cycle issues address 0 of new bank, no gap in ovld.
REQ-024 Read of LEN-1 with no pending swap: read goes inactive; ovld low after last sample presented.
REQ-025 Swap during active read (misaligned frame): rcnt restarts at 0 on new bank; old frame truncated, no osync for it.
REQ-026 Before first accepted isync after reset, ovld SHALL remain 0.
REQ-027 Data passes unmodified; no arithmetic, no width change.

Reset
REQ-028 On rst: wcnt=0, rcnt=0, write bank=0, read inactive, ovld=0, osync=0, sync_err=0, oidx=0, out_re=out_im=0; bank contents undefined.
REQ-029 rst mid-frame SHALL discard partial input and in-flight output; next output only after a complete post-reset frame and isync.

Verification (STG=4, LEN=16, DW=16)
REQ-030 en=1, one frame with in_re=bitrev(k)*100, in_im=-in_re, isync on k=15 -> 2 cycles later ovld=1, out_re=0,100,...,1500, oidx 0..15, osync only at oidx=15.
REQ-031 Three back-to-back frames, en=1 -> ovld continuous 48 cycles, osync every 16th, no sync_err.
REQ-032 en toggled 1,0 pattern during frame -> same output sequence as REQ-030, outputs frozen while en=0.
REQ-033 isync after 10 samples -> sync_err pulse, wcnt restarts, following full frame reordered correctly.
REQ-034 rst for 2 cycles at sample 7 of frame 2 -> ovld=0 at once, stays 0 until a full new frame plus isync; then correct output.
